// File: rtl/id_stage_ctrl_pkg.sv
// id_stage_ctrl_pkg
//   Shared definitions for the RV32I decode-stage sequencer:
//   opcode constants, instruction field positions/widths, the
//   instruction-ID width, On/Off constants and the slot state encoding.
`ifndef INST_ID_LEN
`define INST_ID_LEN 8
`endif

package id_stage_ctrl_pkg;

    localparam int unsigned INST_ID_W = `INST_ID_LEN;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    // Field positions and widths
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned F3_LSB  = 12;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned F7_LSB  = 25;
    localparam int unsigned F7_W    = 7;
    localparam int unsigned REG_W   = 5;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    // Encoded as {skid_valid, main_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_MAIN  = 2'b01,
        ST_FULL  = 2'b11
    } id_state_e;

endpackage

// File: rtl/id_hazard_unit.sv
// id_hazard_unit
//   Combinational load-use hazard detection for the main decode slot.
//   Ports:
//     main_valid_i    main slot holds an instruction
//     opcode_i        main-slot opcode
//     rs1_i / rs2_i   main-slot source register fields
//     ex_load_valid_i instruction in EX is a load
//     ex_load_rd_i    destination of that load
//     hazard_o        main slot must be held this cycle
module id_hazard_unit
    import id_stage_ctrl_pkg::*;
(
    input  logic               main_valid_i,
    input  logic [OPC_W-1:0]   opcode_i,
    input  logic [REG_W-1:0]   rs1_i,
    input  logic [REG_W-1:0]   rs2_i,
    input  logic               ex_load_valid_i,
    input  logic [REG_W-1:0]   ex_load_rd_i,
    output logic               hazard_o
);

    logic uses_rs1;
    logic uses_rs2;
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        uses_rs1 = !((opcode_i == LUI) || (opcode_i == AUIPC) || (opcode_i == JAL));
        uses_rs2 = (opcode_i == OP) || (opcode_i == STORE) || (opcode_i == BRANCH);
        rs1_hit  = uses_rs1 && (rs1_i == ex_load_rd_i);
        rs2_hit  = uses_rs2 && (rs2_i == ex_load_rd_i);
        // x0 is hard-wired zero, so a load targeting it never blocks.
        hazard_o = main_valid_i && ex_load_valid_i && (ex_load_rd_i != '0)
                   && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl
//   Decode-stage sequencer between IF and EX: main slot plus one-entry
//   skid buffer, drives fields to the instruction identifier, forwards the
//   identified instruction to EX, inserts load-use bubbles, handles flush.
//   Ports:
//     clk_i, rst_n_i                     clock, async active-low reset
//     if_valid_i/if_instr_i/if_pc_i      fetch beat
//     if_ready_o                         ID can accept (registered)
//     opcode_o/funct3_o/funct7_o         main-slot fields to identifier
//     instr_id_i                         identifier result
//     ex_valid_o/ex_ready_i              handshake to EX
//     ex_instr_id_o/ex_pc_o/ex_instr_o   main-slot payload to EX
//     ex_rd_o/ex_rs1_o/ex_rs2_o          register indices
//     ex_load_valid_i/ex_load_rd_i       load currently in EX
//     flush_i                            redirect, kill ID contents
//     stall_o                            load-use bubble this cycle
module id_stage_ctrl
    import id_stage_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ID_W = `INST_ID_LEN
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            if_valid_i,
    input  logic [XLEN-1:0] if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            if_ready_o,
    output logic [6:0]      opcode_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    input  logic [ID_W-1:0] instr_id_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [ID_W-1:0] ex_instr_id_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_instr_o,
    output logic [4:0]      ex_rd_o,
    output logic [4:0]      ex_rs1_o,
    output logic [4:0]      ex_rs2_o,
    input  logic            ex_load_valid_i,
    input  logic [4:0]      ex_load_rd_i,
    input  logic            flush_i,
    output logic            stall_o
);

    id_state_e       state_q;
    logic            if_ready_q;
    logic [XLEN-1:0] main_instr_q;
    logic [XLEN-1:0] main_pc_q;
    logic [XLEN-1:0] skid_instr_q;
    logic [XLEN-1:0] skid_pc_q;

    logic main_valid;
    logic hazard;
    logic accept;
    logic leave;

    assign main_valid = (state_q != ST_EMPTY);

    id_hazard_unit u_hazard (
        .main_valid_i    (main_valid),
        .opcode_i        (main_instr_q[OPC_LSB +: OPC_W]),
        .rs1_i           (main_instr_q[RS1_LSB +: REG_W]),
        .rs2_i           (main_instr_q[RS2_LSB +: REG_W]),
        .ex_load_valid_i (ex_load_valid_i),
        .ex_load_rd_i    (ex_load_rd_i),
        .hazard_o        (hazard)
    );

    always_comb begin
        accept     = if_valid_i && if_ready_q && !flush_i;
        ex_valid_o = main_valid && !hazard && !flush_i;
        stall_o    = main_valid && hazard && !flush_i;
        leave      = ex_valid_o && ex_ready_i;
    end

    // if_ready is registered as the complement of the next skid_valid,
    // so it is updated alongside every state change below.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_EMPTY;
            if_ready_q   <= ON;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else if (flush_i) begin
            state_q    <= ST_EMPTY;
            if_ready_q <= ON;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_instr_q <= if_instr_i;
                        main_pc_q    <= if_pc_i;
                        state_q      <= ST_MAIN;
                    end
                    if_ready_q <= ON;
                end
                ST_MAIN: begin
                    if (accept && leave) begin
                        main_instr_q <= if_instr_i;
                        main_pc_q    <= if_pc_i;
                        if_ready_q   <= ON;
                    end else if (accept) begin
                        skid_instr_q <= if_instr_i;
                        skid_pc_q    <= if_pc_i;
                        state_q      <= ST_FULL;
                        if_ready_q   <= OFF;
                    end else if (leave) begin
                        state_q    <= ST_EMPTY;
                        if_ready_q <= ON;
                    end
                end
                ST_FULL: begin
                    if (leave) begin
                        main_instr_q <= skid_instr_q;
                        main_pc_q    <= skid_pc_q;
                        state_q      <= ST_MAIN;
                        if_ready_q   <= ON;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    if_ready_q <= ON;
                end
            endcase
        end
    end

    assign if_ready_o    = if_ready_q;
    assign opcode_o      = main_instr_q[OPC_LSB +: OPC_W];
    assign funct3_o      = main_instr_q[F3_LSB +: F3_W];
    assign funct7_o      = main_instr_q[F7_LSB +: F7_W];
    assign ex_instr_id_o = instr_id_i;
    assign ex_pc_o       = main_pc_q;
    assign ex_instr_o    = main_instr_q;
    assign ex_rd_o       = main_instr_q[RD_LSB +: REG_W];
    assign ex_rs1_o      = main_instr_q[RS1_LSB +: REG_W];
    assign ex_rs2_o      = main_instr_q[RS2_LSB +: REG_W];

endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb_id_stage_ctrl
//   Self-checking bench for id_stage_ctrl: hand-written reset sequence,
//   then a table of per-cycle vectors with expected handshake/stall values;
//   accepted beats go to a scoreboard queue and are compared when EX takes them.
module tb_id_stage_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        if_valid_i;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic        if_ready_o;
    logic [6:0]  opcode_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [7:0]  instr_id_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [7:0]  ex_instr_id_o;
    logic [31:0] ex_pc_o;
    logic [31:0] ex_instr_o;
    logic [4:0]  ex_rd_o;
    logic [4:0]  ex_rs1_o;
    logic [4:0]  ex_rs2_o;
    logic        ex_load_valid_i;
    logic [4:0]  ex_load_rd_i;
    logic        flush_i;
    logic        stall_o;

    id_stage_ctrl #(.XLEN(32), .ID_W(8)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .if_valid_i      (if_valid_i),
        .if_instr_i      (if_instr_i),
        .if_pc_i         (if_pc_i),
        .if_ready_o      (if_ready_o),
        .opcode_o        (opcode_o),
        .funct3_o        (funct3_o),
        .funct7_o        (funct7_o),
        .instr_id_i      (instr_id_i),
        .ex_valid_o      (ex_valid_o),
        .ex_ready_i      (ex_ready_i),
        .ex_instr_id_o   (ex_instr_id_o),
        .ex_pc_o         (ex_pc_o),
        .ex_instr_o      (ex_instr_o),
        .ex_rd_o         (ex_rd_o),
        .ex_rs1_o        (ex_rs1_o),
        .ex_rs2_o        (ex_rs2_o),
        .ex_load_valid_i (ex_load_valid_i),
        .ex_load_rd_i    (ex_load_rd_i),
        .flush_i         (flush_i),
        .stall_o         (stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        rdy;
        logic        lv;
        logic [4:0]  lrd;
        logic        fl;
        logic        e_ifr;
        logic        e_exv;
        logic        e_stl;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } beat_t;

    vec_t  vecs[$];
    beat_t sb[$];
    vec_t  t;
    beat_t h;
    beat_t nb;
    int    checks   = 0;
    int    failures = 0;

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, 3'b000, rd, opc};
    endfunction

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd);
        return i_type(12'(rd), 5'd0, rd, 7'b0010011);
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                input logic rdy, input logic lv, input logic [4:0] lrd,
                                input logic fl, input logic e_ifr, input logic e_exv,
                                input logic e_stl);
        vec_t r;
        r.v = v; r.ins = ins; r.pc = pc; r.rdy = rdy; r.lv = lv; r.lrd = lrd; r.fl = fl;
        r.e_ifr = e_ifr; r.e_exv = e_exv; r.e_stl = e_stl;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic lv, input logic [4:0] lrd, input logic fl);
        if_valid_i      = v;
        if_instr_i      = ins;
        if_pc_i         = pc;
        ex_ready_i      = rdy;
        ex_load_valid_i = lv;
        ex_load_rd_i    = lrd;
        flush_i         = fl;
        instr_id_i      = 8'($urandom);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ready"}, 32'(if_ready_o), 32'd1);
        chk({nm, "_exv"},   32'(ex_valid_o), 32'd0);
        chk({nm, "_pc"},    ex_pc_o,         32'd0);
        chk({nm, "_instr"}, ex_instr_o,      32'd0);
        chk({nm, "_regs"},  32'({ex_rd_o, ex_rs1_o, ex_rs2_o}), 32'd0);
    endtask

    initial begin
        // ---------------- reset sequences ----------------
        rst_n_i = 1'b0;
        drive(1'b1, addi(5'd1), 32'h100, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk_i); #2;
        chk_zero("rst_init");
        chk("rst_init_stall", 32'(stall_o), 32'd0);

        @(negedge clk_i);
        rst_n_i = 1'b1;
        #2;
        chk("rel1_exv", 32'(ex_valid_o), 32'd0);
        @(negedge clk_i);
        drive(1'b1, addi(5'd2), 32'h104, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        chk("rel1_exv_after", 32'(ex_valid_o), 32'd1);
        chk("rel1_pc",        ex_pc_o,         32'h100);
        @(negedge clk_i); #2;
        chk("full_ready", 32'(if_ready_o), 32'd0);

        // Reset while FULL with fetch still offering a beat.
        rst_n_i = 1'b0;
        drive(1'b1, addi(5'd3), 32'h108, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        chk_zero("rst_mid");
        @(negedge clk_i); #2;
        chk("rst_mid_hold_exv", 32'(ex_valid_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        drive(1'b1, addi(5'd7), 32'h200, 1'b1, 1'b0, 5'd0, 1'b0);
        #2;
        chk("rel2_exv", 32'(ex_valid_o), 32'd0);
        @(negedge clk_i);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        #2;
        chk("rel2_exv_after", 32'(ex_valid_o), 32'd1);
        chk("rel2_pc",        ex_pc_o,         32'h200);
        chk("rel2_rd",        32'(ex_rd_o),    32'd7);
        @(negedge clk_i); #2;
        chk("rel2_empty", 32'(ex_valid_o), 32'd0);

        // ---------------- vector table ----------------
        //               v     instr               pc     rdy  lv  lrd  fl   ifr exv stl
        // back-to-back ADDI x1..x4
        vecs.push_back(mk(1, addi(5'd1),          32'h00, 1, 0, 5'd0, 0,  1, 0, 0));
        vecs.push_back(mk(1, addi(5'd2),          32'h04, 1, 0, 5'd0, 0,  1, 1, 0));
        vecs.push_back(mk(1, addi(5'd3),          32'h08, 1, 0, 5'd0, 0,  1, 1, 0));
        vecs.push_back(mk(1, addi(5'd4),          32'h0C, 1, 0, 5'd0, 0,  1, 1, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 0, 5'd0, 0,  1, 1, 0));
        // EX back-pressure fills the skid buffer
        vecs.push_back(mk(1, addi(5'd1),          32'h10, 1, 0, 5'd0, 0,  1, 0, 0));
        vecs.push_back(mk(1, addi(5'd2),          32'h14, 0, 0, 5'd0, 0,  1, 1, 0));
        vecs.push_back(mk(1, addi(5'd3),          32'h18, 0, 0, 5'd0, 0,  0, 1, 0));
        vecs.push_back(mk(1, addi(5'd3),          32'h18, 0, 0, 5'd0, 0,  0, 1, 0));
        vecs.push_back(mk(1, addi(5'd3),          32'h18, 1, 0, 5'd0, 0,  0, 1, 0));
        vecs.push_back(mk(1, addi(5'd3),          32'h18, 1, 0, 5'd0, 0,  1, 1, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 0, 5'd0, 0,  1, 1, 0));
        // load-use on rs1: ADD x6,x5,x7 behind LW x5
        vecs.push_back(mk(1, r_add(5'd6,5'd5,5'd7), 32'h20, 1, 0, 5'd0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 1, 5'd5, 0,  1, 0, 1));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 0, 5'd0, 0,  1, 1, 0));
        // LUI x5 (rs1 field = 5 but unused)
        vecs.push_back(mk(1, {20'h00028, 5'd5, 7'b0110111}, 32'h24, 1, 0, 5'd0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 1, 5'd5, 0,  1, 1, 0));
        // load to x0 never stalls
        vecs.push_back(mk(1, r_add(5'd6,5'd0,5'd7), 32'h28, 1, 0, 5'd0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 1, 5'd0, 0,  1, 1, 0));
        // load-use on rs2
        vecs.push_back(mk(1, r_add(5'd6,5'd7,5'd5), 32'h2C, 1, 0, 5'd0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 1, 5'd5, 0,  1, 0, 1));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 0, 5'd0, 0,  1, 1, 0));
        // ADDI x6,x7,5: rs2 field matches but OP-IMM has no rs2
        vecs.push_back(mk(1, i_type(12'd5,5'd7,5'd6,7'b0010011), 32'h30, 1, 0, 5'd0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 1, 5'd5, 0,  1, 1, 0));
        // flush while FULL, beat offered in flush cycle is dropped
        vecs.push_back(mk(1, addi(5'd1),          32'h40, 0, 0, 5'd0, 0,  1, 0, 0));
        vecs.push_back(mk(1, addi(5'd2),          32'h44, 0, 0, 5'd0, 0,  1, 1, 0));
        vecs.push_back(mk(1, addi(5'd3),          32'h48, 1, 0, 5'd0, 1,  0, 0, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 0, 5'd0, 0,  1, 0, 0));
        // flush while EMPTY with a valid beat: not accepted
        vecs.push_back(mk(1, addi(5'd4),          32'h4C, 1, 0, 5'd0, 1,  1, 0, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 0, 5'd0, 0,  1, 0, 0));
        // flush coinciding with a hazard
        vecs.push_back(mk(1, r_add(5'd6,5'd5,5'd7), 32'h50, 1, 0, 5'd0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 1, 5'd5, 1,  1, 0, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 0, 5'd0, 0,  1, 0, 0));
        // hazard while fetch keeps streaming: beat parks in skid
        vecs.push_back(mk(1, r_add(5'd6,5'd5,5'd7), 32'h60, 1, 0, 5'd0, 0, 1, 0, 0));
        vecs.push_back(mk(1, addi(5'd2),          32'h64, 1, 1, 5'd5, 0,  1, 0, 1));
        vecs.push_back(mk(1, addi(5'd3),          32'h68, 1, 0, 5'd0, 0,  0, 1, 0));
        vecs.push_back(mk(1, addi(5'd3),          32'h68, 1, 0, 5'd0, 0,  1, 1, 0));
        vecs.push_back(mk(0, 32'd0,               32'h00, 1, 0, 5'd0, 0,  1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            @(negedge clk_i);
            drive(t.v, t.ins, t.pc, t.rdy, t.lv, t.lrd, t.fl);
            #2;
            chk($sformatf("v%0d_ifready", i), 32'(if_ready_o), 32'(t.e_ifr));
            chk($sformatf("v%0d_exvalid", i), 32'(ex_valid_o), 32'(t.e_exv));
            chk($sformatf("v%0d_stall",   i), 32'(stall_o),    32'(t.e_stl));
            chk($sformatf("v%0d_instrid", i), 32'(ex_instr_id_o), 32'(instr_id_i));
            if (t.e_exv) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL v%0d_sb: got ex_valid with pc 0x%0h expected no pending beat", i, ex_pc_o);
                end else begin
                    h = sb[0];
                    chk($sformatf("v%0d_pc",    i), ex_pc_o,           h.pc);
                    chk($sformatf("v%0d_instr", i), ex_instr_o,        h.ins);
                    chk($sformatf("v%0d_rd",    i), 32'(ex_rd_o),      32'(h.ins[11:7]));
                    chk($sformatf("v%0d_rs1",   i), 32'(ex_rs1_o),     32'(h.ins[19:15]));
                    chk($sformatf("v%0d_rs2",   i), 32'(ex_rs2_o),     32'(h.ins[24:20]));
                    chk($sformatf("v%0d_fields",i), 32'({funct7_o, funct3_o, opcode_o}),
                        32'({h.ins[31:25], h.ins[14:12], h.ins[6:0]}));
                end
            end
            if (t.fl) begin
                sb.delete();
            end else begin
                if (t.e_exv && t.rdy && sb.size() > 0) void'(sb.pop_front());
                if (t.v && t.e_ifr) begin
                    nb.pc  = t.pc;
                    nb.ins = t.ins;
                    sb.push_back(nb);
                end
            end
        end

        @(negedge clk_i); #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("end_exv",    32'(ex_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Decode-stage sequencer for the RV32I core. It sits between fetch (IF) and execute (EX).
- Holds the instruction in a main slot plus a one-entry skid buffer, and drives the opcode/funct3/funct7 fields to the combinational instruction identifier.
- Forwards the returned instruction ID with PC and register indices to EX under a valid/ready handshake.
- Inserts load-use bubbles and handles branch flush.

Parameters:
- XLEN, 32, instruction and PC width.
- ID_W, 8, width of the instruction ID; must equal `INST_ID_LEN.

Ports:
- clk_i  in  1  core clock, all state on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low; one clock, no other clock domains
- if_valid_i  in  1  fetch presents an instruction
- if_instr_i  in  XLEN  fetched instruction word
- if_pc_i  in  XLEN  PC of fetched instruction
- if_ready_o  out  1  ID can accept a beat (registered)
- opcode_o  out  7  main-slot instr[6:0] to identifier
- funct3_o  out  3  main-slot instr[14:12] to identifier
- funct7_o  out  7  main-slot instr[31:25] to identifier
- instr_id_i  in  ID_W  identifier result for main slot
- ex_valid_o  out  1  decoded instruction valid to EX
- ex_ready_i  in  1  EX accepts this cycle
- ex_instr_id_o  out  ID_W  pass-through of instr_id_i
- ex_pc_o  out  XLEN  main-slot PC
- ex_instr_o  out  XLEN  main-slot word (immediate generation downstream)
- ex_rd_o / ex_rs1_o / ex_rs2_o  out  5 each  instr[11:7] / [19:15] / [24:20]
- ex_load_valid_i  in  1  instruction currently in EX is a load
- ex_load_rd_i  in  5  destination of that load
- flush_i  in  1  taken branch/jump redirect; kill ID contents
- stall_o  out  1  load-use bubble inserted this cycle (for perf counter)

Behaviour:
- Reset (async assert, sync-safe deassert):
  - main_valid = 0, skid_valid = 0, if_ready_o = 1.
  - Slot data cleared to 0, so ex_* fields are 0 and ex_valid_o = 0.
- States, encoded by {skid_valid, main_valid}: EMPTY (00), MAIN (01), FULL (11). Encoding 10 is illegal and never reached.
- Signal definitions:
  - accept = if_valid_i & if_ready_o & ~flush_i.
  - hazard = main_valid & ex_load_valid_i & (ex_load_rd_i != 0) & ((uses_rs1 & rs1 == ex_load_rd_i) | (uses_rs2 & rs2 == ex_load_rd_i)).
  - uses_rs1 = 0 for opcodes LUI 0110111, AUIPC 0010111, JAL 1101111; 1 otherwise.
  - uses_rs2 = 1 only for OP 0110011, STORE 0100011, BRANCH 1100011.
  - ex_valid_o = main_valid & ~hazard & ~flush_i.
  - stall_o = main_valid & hazard & ~flush_i.
  - leave = ex_valid_o & ex_ready_i.
- Transitions (if not flushing):
  - EMPTY: on accept, beat loads main → MAIN.
  - MAIN: accept & leave → main replaced by new beat, stay MAIN. Accept only → beat goes to skid → FULL. Leave only → EMPTY.
  - FULL (if_ready_o = 0): on leave, skid moves to main → MAIN.
- if_ready_o registered: next value = ~next_skid_valid.
- Flush has highest priority:
  - Next edge, main_valid = skid_valid = 0 → EMPTY, if_ready_o = 1.
  - The IF beat offered in the flush cycle is dropped.
  - ex_valid_o = 0 in the flush cycle even if EX is ready.
- Hazard:
  - Main slot held and EX sees a bubble.
  - Clears automatically when ex_load_valid_i drops or the rd differs.
  - No internal timeout; one bubble per cycle the condition holds.
- x0 never causes a hazard.
- Reset mid-transfer: all in-flight beats are lost and no ex_valid_o is emitted until a new accept.
- Latency: IF beat accepted at edge N is offered to EX in cycle N+1 (one cycle through ID).
- Throughput: one instruction per cycle when no stall.

Decomposition:
- Shared package/defines:
  - opcode constants (OP_IMM, OP, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
  - field bit ranges and widths;
  - ID_W via `INST_ID_LEN;
  - On/Off constants.
- One natural sub-module: id_hazard_unit, combinational, computing uses_rs1/uses_rs2/hazard. Keep the slot/skid logic in the top.

Test Plan:
- Reset with rst_n_i low mid-stream, if_valid_i=1 → if_ready_o=1, ex_valid_o=0, all ex_* zero; first beat after release appears one cycle later.
- Back-to-back ADDI x1..x4 (PC 0x0,0x4,0x8,0xC), ex_ready_i=1 → ex_valid_o high 4 consecutive cycles, ex_pc_o 0x0..0xC in order, ex_rd_o 1..4.
- ex_ready_i=0 for 3 cycles during stream → skid fills, if_ready_o=0 from next cycle; on release, PC order preserved with no loss or duplication.
- LW x5 in EX (ex_load_valid_i=1, ex_load_rd_i=5), ID holds ADD x6,x5,x7 → ex_valid_o=0, stall_o=1 one cycle. Next cycle the load is gone and ADD issues. Repeat with LUI x5 and rd=0: no stall.
- FULL state with flush_i=1 and if_valid_i=1 → ex_valid_o=0 that cycle; next cycle EMPTY, if_ready_o=1, the offered beat is never seen at EX.
- flush_i and a hazard coincide → stall_o=0, ex_valid_o=0, state EMPTY after the edge.
